// File: rtl/reg_file_rv32i_if.sv
// Register-file access bundle: two read ports and one write port.
// Latency: none (wires only). Backpressure: none; the write port is always accepted.
// Not clocked: clk/rst stay plain ports on the register file itself.
interface reg_file_rv32i_if #(
   parameter int DATA_WIDTH = 32
);
   logic [4:0]            rs1_addr;
   logic [4:0]            rs2_addr;
   logic [DATA_WIDTH-1:0] rs1_data;
   logic [DATA_WIDTH-1:0] rs2_data;
   logic                  reg_write;
   logic [4:0]            rd_addr;
   logic [DATA_WIDTH-1:0] rd_wdata;

   modport master (
      output rs1_addr, rs2_addr, reg_write, rd_addr, rd_wdata,
      input  rs1_data, rs2_data
   );

   modport slave (
      input  rs1_addr, rs2_addr, reg_write, rd_addr, rd_wdata,
      output rs1_data, rs2_data
   );
endinterface

// File: rtl/reg_file_rv32i.sv
// RV32I integer register file, x0 hardwired to zero; REG_FILE_BYPASS_EN adds write-to-read forwarding.
// Latency: reads are combinational (0 cycles); writes are visible after the next clk edge.
// Backpressure: none; a write issued with reg_write=1 always commits unless rst is high.
module reg_file_rv32i #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32
) (
   input  logic              clk,
   input  logic              rst,
   reg_file_rv32i_if.slave   rf
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   function automatic logic in_range(input logic [4:0] addr);
      return (int'(addr) < NUM_REGS);
   endfunction

   // Reset clears every entry in one edge and takes priority over the write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (rf.reg_write && (rf.rd_addr != 5'd0) && in_range(rf.rd_addr)) begin
         regs[rf.rd_addr] <= rf.rd_wdata;
      end
   end

   function automatic logic [DATA_WIDTH-1:0] read_entry(input logic [4:0] addr);
      logic [DATA_WIDTH-1:0] val;
      val = '0;
      if ((addr != 5'd0) && in_range(addr)) begin
         val = regs[addr];
      end
      return val;
   endfunction

`ifdef REG_FILE_BYPASS_EN
   logic fwd_vld;

   // rd_addr!=0 in the qualifier keeps x0 reads at zero even while forwarding.
   always_comb begin
      fwd_vld = rf.reg_write && !rst && (rf.rd_addr != 5'd0);
   end

   always_comb begin
      rf.rs1_data = read_entry(rf.rs1_addr);
      rf.rs2_data = read_entry(rf.rs2_addr);
      if (fwd_vld && (rf.rs1_addr == rf.rd_addr)) begin
         rf.rs1_data = rf.rd_wdata;
      end
      if (fwd_vld && (rf.rs2_addr == rf.rd_addr)) begin
         rf.rs2_data = rf.rd_wdata;
      end
   end
`else
   always_comb begin
      rf.rs1_data = read_entry(rf.rs1_addr);
      rf.rs2_data = read_entry(rf.rs2_addr);
   end
`endif

endmodule

// File: tb/tb_reg_file_rv32i.sv
// Directed bench for reg_file_rv32i: driver pushes expected read data into a scoreboard queue,
// a negedge monitor pops and compares whenever a read vector is presented.
module tb_reg_file_rv32i;

   localparam bit BYP =
`ifdef REG_FILE_BYPASS_EN
      1'b1;
`else
      1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   reg_file_rv32i_if #(.DATA_WIDTH(32)) rf_if ();

   reg_file_rv32i #(
      .DATA_WIDTH(32),
      .NUM_REGS  (32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rf (rf_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [31:0] e1;
      logic [31:0] e2;
   } exp_t;

   exp_t sb_q[$];
   logic chk_req = 1'b0;
   int   n_vec   = 0;
   int   n_err   = 0;

   // Monitor: compares at the falling edge, well away from the write edge.
   always @(negedge clk) begin
      exp_t e;
      if (chk_req) begin
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: read presented with no expected entry");
         end else begin
            e = sb_q.pop_front();
            n_vec++;
            if ((rf_if.rs1_data !== e.e1) || (rf_if.rs2_data !== e.e2)) begin
               n_err++;
               $display("FAIL %s: got rs1=%h rs2=%h, expected rs1=%h rs2=%h",
                        e.nm, rf_if.rs1_data, rf_if.rs2_data, e.e1, e.e2);
            end
         end
      end
   end

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      rf_if.reg_write = 1'b1;
      rf_if.rd_addr   = a;
      rf_if.rd_wdata  = d;
      @(posedge clk);
      #1;
      rf_if.reg_write = 1'b0;
   endtask

   // Presents a read for one cycle; whatever write/reset is set up commits on the closing edge.
   task automatic rd_chk(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2, input string nm);
      exp_t e;
      rf_if.rs1_addr = a1;
      rf_if.rs2_addr = a2;
      e.nm = nm;
      e.e1 = e1;
      e.e2 = e2;
      sb_q.push_back(e);
      chk_req = 1'b1;
      @(posedge clk);
      #1;
      chk_req = 1'b0;
   endtask

   function automatic logic [31:0] pat(input int i);
      return 32'hC0DE0000 | 32'(i);
   endfunction

   initial begin
      rst             = 1'b1;
      rf_if.reg_write = 1'b0;
      rf_if.rd_addr   = 5'd0;
      rf_if.rd_wdata  = 32'h0;
      rf_if.rs1_addr  = 5'd0;
      rf_if.rs2_addr  = 5'd0;
      @(posedge clk);
      #1;

      // Outputs while reset is still held, then every register after release.
      rd_chk(5'd1, 5'd31, 32'h0, 32'h0, "rst_hold");
      rst = 1'b0;
      for (int i = 1; i < 32; i++) begin
         rd_chk(5'(i), 5'(i), 32'h0, 32'h0, "rst_clear");
      end

      wr(5'd5, 32'hAAAAAAAA);
      wr(5'd6, 32'h55555555);
      rd_chk(5'd5, 5'd6, 32'hAAAAAAAA, 32'h55555555, "x5_x6");
      rd_chk(5'd6, 5'd6, 32'h55555555, 32'h55555555, "same_addr");

      // reg_write low must leave x5 untouched.
      rf_if.rd_addr  = 5'd5;
      rf_if.rd_wdata = 32'hDEADBEEF;
      rd_chk(5'd5, 5'd6, 32'hAAAAAAAA, 32'h55555555, "we0_pre");
      rd_chk(5'd5, 5'd6, 32'hAAAAAAAA, 32'h55555555, "we0_post");

      // Write to x0: zero during the write cycle and afterwards.
      rf_if.reg_write = 1'b1;
      rf_if.rd_addr   = 5'd0;
      rf_if.rd_wdata  = 32'h12345678;
      rd_chk(5'd0, 5'd0, 32'h0, 32'h0, "x0_same");
      rf_if.reg_write = 1'b0;
      rd_chk(5'd0, 5'd0, 32'h0, 32'h0, "x0_after");

      // Same-cycle read of the register being written.
      wr(5'd7, 32'h87654321);
      rd_chk(5'd7, 5'd0, 32'h87654321, 32'h0, "x7_old");
      rf_if.reg_write = 1'b1;
      rf_if.rd_addr   = 5'd7;
      rf_if.rd_wdata  = 32'hFEDCBA98;
      rd_chk(5'd7, 5'd7, BYP ? 32'hFEDCBA98 : 32'h87654321,
             BYP ? 32'hFEDCBA98 : 32'h87654321, "x7_same");
      rf_if.reg_write = 1'b0;
      rd_chk(5'd7, 5'd7, 32'hFEDCBA98, 32'hFEDCBA98, "x7_new");

      // Reset beats a simultaneous write; no forwarding while rst is high.
      wr(5'd9, 32'hABCDEF01);
      rd_chk(5'd9, 5'd5, 32'hABCDEF01, 32'hAAAAAAAA, "x9_stored");
      rst             = 1'b1;
      rf_if.reg_write = 1'b1;
      rf_if.rd_addr   = 5'd9;
      rf_if.rd_wdata  = 32'h11111111;
      rd_chk(5'd9, 5'd5, 32'hABCDEF01, 32'hAAAAAAAA, "x9_rst_nofwd");

      // First edge after reset release accepts a write.
      rst             = 1'b0;
      rf_if.rd_wdata  = 32'h13579BDF;
      rd_chk(5'd9, 5'd5, BYP ? 32'h13579BDF : 32'h0, 32'h0, "x9_cleared");
      rf_if.reg_write = 1'b0;
      rd_chk(5'd9, 5'd7, 32'h13579BDF, 32'h0, "x9_first_wr");

      // x31 with reg_write low, then fill x1..x30 and write x31 for real.
      rf_if.rd_addr  = 5'd31;
      rf_if.rd_wdata = 32'hFFFFFFFF;
      rd_chk(5'd31, 5'd31, 32'h0, 32'h0, "x31_we0_pre");
      rd_chk(5'd31, 5'd31, 32'h0, 32'h0, "x31_we0");
      for (int i = 1; i < 31; i++) begin
         wr(5'(i), pat(i));
      end
      wr(5'd31, 32'hFFFFFFFF);
      rd_chk(5'd31, 5'd0, 32'hFFFFFFFF, 32'h0, "x31_we1");
      for (int i = 1; i < 31; i++) begin
         rd_chk(5'(i), 5'(31 - i), pat(i), pat(31 - i), "x1_x30_kept");
      end

      for (int t = 0; t < 20 && sb_q.size() != 0; t++) begin
         @(posedge clk);
      end
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/reg_file_rv32i.md
REG_FILE_RV32I -- requirements
Module: reg_file_rv32i

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the register and data-port width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, giving the number of architectural registers (x0..x31); address width SHALL be 5 bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rs1_addr  input  5  read port 1 register index.
REQ-006 rs2_addr  input  5  read port 2 register index.
REQ-007 rs1_data  output  DATA_WIDTH  read port 1 data; feeds the ALU operand A select.
REQ-008 rs2_data  output  DATA_WIDTH  read port 2 data; feeds the in0 leg of the downstream 2:1 ALU operand B select (in1 = immediate).
REQ-009 reg_write  input  1  write enable for the write port.
REQ-010 rd_addr  input  5  write port register index.
REQ-011 rd_wdata  input  DATA_WIDTH  write port data.

Function
REQ-012 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-013 Storage: NUM_REGS entries of DATA_WIDTH bits each; entry 0 SHALL always read 0.
REQ-014 Write: on a rising clk edge with rst=0, reg_write=1 and rd_addr!=0, entry[rd_addr] SHALL take rd_wdata.
REQ-015 A write with rd_addr=0 SHALL be discarded, with no state change.
REQ-016 reg_write=0 SHALL leave all entries unchanged, regardless of rd_addr and rd_wdata.
REQ-017 Read: rs1_data and rs2_data SHALL be combinational functions of rs1_addr/rs2_addr and the current entries, with zero-cycle latency.
REQ-018 rs1_addr=0 or rs2_addr=0 SHALL give 0 on the corresponding port in all cases, including a simultaneous write to x0.
REQ-019 Both read ports SHALL be independent; rs1_addr=rs2_addr SHALL return identical data on both ports.
REQ-020 Without bypass (see Configuration), a read of the register being written in the same cycle SHALL return the old value; the new value SHALL be visible from the cycle after the edge.
REQ-021 Write data SHALL be stored at full DATA_WIDTH, with no sign or zero manipulation.

Reset
REQ-022 On a rising clk edge with rst=1, all entries SHALL clear to 0 within that single edge.
REQ-023 When rst=1 and reg_write=1 on the same edge, reset SHALL win and the write SHALL be discarded.
REQ-024 While rst=1, rs1_data and rs2_data SHALL reflect the current entries (all 0 after the first reset edge); no output is registered.
REQ-025 Deasserting rst mid-program SHALL allow a write on the first edge where rst=0.

Configuration
REQ-026 Macro REG_FILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-027 With REG_FILE_BYPASS_EN defined: when reg_write=1, rst=0, rd_addr!=0 and rsN_addr=rd_addr, rsN_data SHALL equal rd_wdata combinationally in the same cycle.
REQ-028 With REG_FILE_BYPASS_EN defined: the x0 rule (REQ-018) and reset priority (REQ-023) SHALL still hold; there is no forwarding when rst=1.
REQ-029 Without REG_FILE_BYPASS_EN: REQ-020 behaviour SHALL apply, and no forwarding logic SHALL be present.

Verification
REQ-030 The bench SHALL cover: rst=1 for 1 edge, then read x1..x31 on both ports -> all read 32'h00000000.
REQ-031 The bench SHALL cover: write x5=32'hAAAAAAAA, then x6=32'h55555555; read rs1=5, rs2=6 -> rs1_data=32'hAAAAAAAA, rs2_data=32'h55555555.
REQ-032 The bench SHALL cover: write x0=32'h12345678, read rs1=0, rs2=0 -> both 32'h00000000 (with and without bypass).
REQ-033 The bench SHALL cover: x7=32'h87654321 stored; same cycle reg_write=1, rd_addr=7, rd_wdata=32'hFEDCBA98, rs1_addr=7 -> rs1_data=32'h87654321 before the edge without REG_FILE_BYPASS_EN, 32'hFEDCBA98 with it; 32'hFEDCBA98 after the edge in both builds.
REQ-034 The bench SHALL cover: x9=32'hABCDEF01 stored; rst=1 with reg_write=1, rd_addr=9, rd_wdata=32'h11111111 on the same edge -> x9 reads 32'h00000000 afterward.
REQ-035 The bench SHALL cover: write x31=32'hFFFFFFFF with reg_write=0 -> x31 stays 32'h00000000; repeat with reg_write=1 -> reads 32'hFFFFFFFF, and x1..x30 are unchanged.
